// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute and drives datapath controls.
// Optional jump support is enabled by defining MC_CTRL_JUMP_EN.
module mc_main_control #(
  parameter int        CNT_W    = 8,
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_BNE   = 6'b000101
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       ALUop,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic             pc_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_op,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [3:0]       state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADDR  = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECUTE  = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [5:0] OP_J       = 6'b000010;
`endif

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       is_mem;
  logic       is_r;
  logic       is_br;
  logic       is_j;
  logic       is_bne;

  assign state  = state_q;
  assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_r   = (opcode == OP_RTYPE);
  assign is_bne = (opcode == OP_BNE);
  assign is_br  = (opcode == OP_BEQ) || is_bne;
`ifdef MC_CTRL_JUMP_EN
  assign is_j   = (opcode == OP_J);
`else
  assign is_j   = 1'b0;
`endif

  assign illegal_op = (state_q == S_DECODE) &&
                      !(is_mem || is_r || is_br || is_j);

  // State register; unknown codes fall back to IDLE via next-state default
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Saturating count of illegal opcodes seen in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= '0;
    else if (illegal_op && (illegal_cnt != {CNT_W{1'b1}}))
      illegal_cnt <= illegal_cnt + CNT_W'(1);
  end

  // Next-state selection
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:  state_d = S_MEMADDR;
          is_r:    state_d = S_EXECUTE;
          is_br:   state_d = S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
          is_j:    state_d = S_JUMP;
`endif
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADDR:  state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
`ifdef MC_CTRL_JUMP_EN
      S_JUMP:     state_d = S_FETCH;
`endif
      default:    state_d = S_IDLE;
    endcase
  end

  // Moore output decode, with mem_ready/zero gating of the PC and IR loads
  always_comb begin
    ALUop      = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        ALUop     = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ALUop     = 2'b01;
        pc_source = 2'b01;
        pc_write  = is_bne ? ~zero : zero;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control.
// Cycle-by-cycle vector table plus reset-abort and counter-saturation sequences.
module tb_mc_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALUop;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal_op;
  logic [7:0] illegal_cnt;
  logic [3:0] state;

  mc_main_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ALUop      (ALUop),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .pc_write   (pc_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal_op (illegal_op),
    .illegal_cnt(illegal_cnt),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ALUop, src_a, src_b, pc_source, pc_write, i_or_d,
  //  mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op}
  logic [15:0] act;
  assign act = {ALUop, alu_src_a, alu_src_b, pc_source, pc_write, i_or_d,
                mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, illegal_op};

  localparam logic [15:0] O_IDLE   = 16'h0000;
  localparam logic [15:0] O_FET_R  = 16'h0950;
  localparam logic [15:0] O_FET_S  = 16'h0840;
  localparam logic [15:0] O_DEC    = 16'h1800;
  localparam logic [15:0] O_DEC_IL = 16'h1801;
  localparam logic [15:0] O_MADDR  = 16'h3000;
  localparam logic [15:0] O_MRD    = 16'h00C0;
  localparam logic [15:0] O_MWB    = 16'h0006;
  localparam logic [15:0] O_MWR    = 16'h00A0;
  localparam logic [15:0] O_EXE    = 16'hA000;
  localparam logic [15:0] O_AWB    = 16'h000A;
  localparam logic [15:0] O_BR_T   = 16'h6300;
  localparam logic [15:0] O_BR_N   = 16'h6200;
  localparam logic [15:0] O_JMP    = 16'h0500;

  localparam logic [5:0] R   = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] ILL = 6'b001000;
  localparam logic [5:0] J   = 6'b000010;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] out;
    logic [7:0]  cnt;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl [NV];

  int n_pass;
  int n_total;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_total++;
    if (a !== e)
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    else
      n_pass++;
  endtask

  initial begin
    int pulses;
    int cyc;
    int expc;
    n_pass  = 0;
    n_total = 0;

    tbl[0]  = '{R,   1'b0, 1'b1, 4'd0, O_IDLE,  8'd0};
    tbl[1]  = '{R,   1'b0, 1'b1, 4'd1, O_FET_R, 8'd0};
    tbl[2]  = '{R,   1'b0, 1'b0, 4'd2, O_DEC,   8'd0};
    tbl[3]  = '{R,   1'b0, 1'b0, 4'd7, O_EXE,   8'd0};
    tbl[4]  = '{R,   1'b0, 1'b0, 4'd8, O_AWB,   8'd0};
    tbl[5]  = '{LW,  1'b0, 1'b1, 4'd1, O_FET_R, 8'd0};
    tbl[6]  = '{LW,  1'b0, 1'b0, 4'd2, O_DEC,   8'd0};
    tbl[7]  = '{LW,  1'b0, 1'b0, 4'd3, O_MADDR, 8'd0};
    tbl[8]  = '{LW,  1'b0, 1'b0, 4'd4, O_MRD,   8'd0};
    tbl[9]  = '{LW,  1'b0, 1'b0, 4'd4, O_MRD,   8'd0};
    tbl[10] = '{LW,  1'b0, 1'b1, 4'd4, O_MRD,   8'd0};
    tbl[11] = '{LW,  1'b0, 1'b0, 4'd5, O_MWB,   8'd0};
    tbl[12] = '{SW,  1'b0, 1'b0, 4'd1, O_FET_S, 8'd0};
    tbl[13] = '{SW,  1'b0, 1'b1, 4'd1, O_FET_R, 8'd0};
    tbl[14] = '{SW,  1'b0, 1'b1, 4'd2, O_DEC,   8'd0};
    tbl[15] = '{SW,  1'b0, 1'b1, 4'd3, O_MADDR, 8'd0};
    tbl[16] = '{SW,  1'b0, 1'b1, 4'd6, O_MWR,   8'd0};
    tbl[17] = '{BEQ, 1'b1, 1'b1, 4'd1, O_FET_R, 8'd0};
    tbl[18] = '{BEQ, 1'b1, 1'b1, 4'd2, O_DEC,   8'd0};
    tbl[19] = '{BEQ, 1'b1, 1'b1, 4'd9, O_BR_T,  8'd0};
    tbl[20] = '{BEQ, 1'b0, 1'b1, 4'd1, O_FET_R, 8'd0};
    tbl[21] = '{BEQ, 1'b0, 1'b1, 4'd2, O_DEC,   8'd0};
    tbl[22] = '{BEQ, 1'b0, 1'b1, 4'd9, O_BR_N,  8'd0};
    tbl[23] = '{BNE, 1'b1, 1'b1, 4'd1, O_FET_R, 8'd0};
    tbl[24] = '{BNE, 1'b1, 1'b1, 4'd2, O_DEC,   8'd0};
    tbl[25] = '{BNE, 1'b1, 1'b1, 4'd9, O_BR_N,  8'd0};
    tbl[26] = '{BNE, 1'b0, 1'b1, 4'd1, O_FET_R, 8'd0};
    tbl[27] = '{BNE, 1'b0, 1'b1, 4'd2, O_DEC,   8'd0};
    tbl[28] = '{BNE, 1'b0, 1'b1, 4'd9, O_BR_T,  8'd0};
    tbl[29] = '{ILL, 1'b0, 1'b1, 4'd1, O_FET_R, 8'd0};
    tbl[30] = '{ILL, 1'b0, 1'b1, 4'd2, O_DEC_IL, 8'd0};
    tbl[31] = '{J,   1'b0, 1'b1, 4'd1, O_FET_R, 8'd1};
`ifdef MC_CTRL_JUMP_EN
    tbl[32] = '{J,   1'b0, 1'b1, 4'd2, O_DEC,   8'd1};
    tbl[33] = '{J,   1'b0, 1'b1, 4'd10, O_JMP,  8'd1};
`else
    tbl[32] = '{J,   1'b0, 1'b1, 4'd2, O_DEC_IL, 8'd1};
    tbl[33] = '{J,   1'b0, 1'b1, 4'd1, O_FET_R, 8'd2};
`endif

    rst_n     = 1'b0;
    opcode    = R;
    zero      = 1'b0;
    mem_ready = 1'b1;

    @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs",  32'(act),   32'(O_IDLE));
    chk("rst_cnt",   32'(illegal_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      opcode    = tbl[i].op;
      zero      = tbl[i].z;
      mem_ready = tbl[i].mr;
      #1;
      chk($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("row%0d_outs", i),  32'(act),   32'(tbl[i].out));
      chk($sformatf("row%0d_cnt", i),   32'(illegal_cnt), 32'(tbl[i].cnt));
      @(negedge clk);
    end

    // Abort a stalled store with reset: write request must drop at once
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    opcode    = SW;
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("sw_pre_state", 32'(state), 32'd6);
    chk("sw_pre_mw",    32'(mem_write), 32'd1);
    @(negedge clk);
    #1;
    chk("sw_stall_state", 32'(state), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_outs",  32'(act),   32'(O_IDLE));
    chk("abort_cnt",   32'(illegal_cnt), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_hold", 32'(act), 32'(O_IDLE));

    // Repeated illegal opcode: counter must saturate at 255
    @(negedge clk);
    opcode    = ILL;
    mem_ready = 1'b1;
    rst_n     = 1'b1;
    pulses    = 0;
    cyc       = 0;
    while (pulses < 300 && cyc < 2000) begin
      #1;
      expc = (pulses > 255) ? 255 : pulses;
      chk("sat_cnt", 32'(illegal_cnt), 32'(expc));
      if (illegal_op) pulses++;
      @(negedge clk);
      cyc++;
    end
    chk("sat_pulses", 32'(pulses), 32'd300);
    chk("sat_cycles", 32'(cyc), 32'd601);
    #1;
    chk("sat_final", 32'(illegal_cnt), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
